// File: rtl/io_timer_unit.sv
// io_timer_unit: 8-bit timer/counter peripheral in IO space.
//
// Decodes the IO-side bus and holds five registers:
//   TCCR  [2:0] CS clock select, [3] CTC clear-on-compare
//   TCNT  counter value
//   OCR   compare value
//   TIMSK [0] TOIE, [1] OCIE
//   TIFR  [0] TOV, [1] OCF (write 1 to clear)
// A 10-bit prescaler divides clk by 1/8/64/256/1024 to produce count ticks.
//
// Ports:
//   clk       clock, rising edge
//   reset     synchronous, active-low
//   bus_addr  IO-relative address
//   bus_data  shared data bus; driven only during a decoded read cycle
//   io_cs     IO chip select
//   io_we     write cycle strobe
//   io_oe     read cycle strobe
//   irq       level interrupt request, |(TIFR & TIMSK)
//
// Build option: define TIMER_COMPARE_EN to implement OCR, OCF, OCIE and CTC.
// Without it those read as 0 and the counter always runs in normal mode.
module io_timer_unit #(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] TCCR_ADDR  = 16'h2D,
  parameter logic [ADDR_WIDTH-1:0] TCNT_ADDR  = 16'h29,
  parameter logic [ADDR_WIDTH-1:0] OCR_ADDR   = 16'h26,
  parameter logic [ADDR_WIDTH-1:0] TIMSK_ADDR = 16'h2B,
  parameter logic [ADDR_WIDTH-1:0] TIFR_ADDR  = 16'h2A
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  inout  wire  [DATA_WIDTH-1:0] bus_data,
  input  logic                  io_cs,
  input  logic                  io_we,
  input  logic                  io_oe,
  output logic                  irq
);

  logic [2:0]            cs_q;
  logic [DATA_WIDTH-1:0] tcnt_q, tcnt_d;
  logic                  toie_q, tov_q;
  logic [9:0]            presc_q, presc_d;

  logic [DATA_WIDTH-1:0] wdata, rd_data;
  logic sel_tccr, sel_tcnt, sel_ocr, sel_timsk, sel_tifr;
  logic hit, wr_en, rd_en;
  logic wr_tccr, wr_tcnt, wr_ocr, wr_timsk, wr_tifr;
  logic running, tick, tick_eff, tov_set;
  logic [9:0] div_last;
  logic ctc_mode, ctc_clear, cmp_irq;

  assign wdata     = bus_data;
  assign sel_tccr  = (bus_addr == TCCR_ADDR);
  assign sel_tcnt  = (bus_addr == TCNT_ADDR);
  assign sel_ocr   = (bus_addr == OCR_ADDR);
  assign sel_timsk = (bus_addr == TIMSK_ADDR);
  assign sel_tifr  = (bus_addr == TIFR_ADDR);
  assign hit       = (io_cs == 1'b1) && (sel_tccr || sel_tcnt || sel_ocr || sel_timsk || sel_tifr);
  assign wr_en     = hit && (io_we == 1'b1);
  assign rd_en     = reset && hit && (io_oe == 1'b1) && (io_we != 1'b1);
  assign wr_tccr   = wr_en && sel_tccr;
  assign wr_tcnt   = wr_en && sel_tcnt;
  assign wr_ocr    = wr_en && sel_ocr;
  assign wr_timsk  = wr_en && sel_timsk;
  assign wr_tifr   = wr_en && sel_tifr;

  // Prescaler terminal count per clock select; CS 0, 6 and 7 stop the timer.
  always_comb begin
    running  = 1'b1;
    div_last = 10'd0;
    case (cs_q)
      3'd1:    div_last = 10'd0;
      3'd2:    div_last = 10'd7;
      3'd3:    div_last = 10'd63;
      3'd4:    div_last = 10'd255;
      3'd5:    div_last = 10'd1023;
      default: running  = 1'b0;
    endcase
  end

  assign tick = running && (presc_q == div_last);

  always_comb begin
    presc_d = presc_q;
    if (wr_tccr && (wdata[2:0] != cs_q)) begin
      presc_d = 10'd0;
    end else if (tick) begin
      presc_d = 10'd0;
    end else if (running) begin
      presc_d = presc_q + 10'd1;
    end
  end

  // A TCNT write in a tick cycle swallows the tick, including its flag effects.
  assign tick_eff = tick && !wr_tcnt;
  assign tov_set  = tick_eff && !ctc_mode && (tcnt_q == {DATA_WIDTH{1'b1}});

  always_comb begin
    tcnt_d = tcnt_q;
    if (wr_tcnt) begin
      tcnt_d = wdata;
    end else if (tick) begin
      tcnt_d = ctc_clear ? '0 : tcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cs_q    <= 3'd0;
      tcnt_q  <= '0;
      toie_q  <= 1'b0;
      tov_q   <= 1'b0;
      presc_q <= 10'd0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      if (wr_tccr)  cs_q   <= wdata[2:0];
      if (wr_timsk) toie_q <= wdata[0];
      // Set beats a simultaneous write-1-to-clear.
      tov_q <= (tov_q & ~(wr_tifr & wdata[0])) | tov_set;
    end
  end

`ifdef TIMER_COMPARE_EN
  logic                  ctc_q, ocie_q, ocf_q, cmp_match, ocf_set;
  logic [DATA_WIDTH-1:0] ocr_q;

  assign cmp_match = (tcnt_q == ocr_q);
  assign ctc_mode  = ctc_q;
  assign ctc_clear = ctc_q && cmp_match;
  assign ocf_set   = tick_eff && cmp_match;
  assign cmp_irq   = ocf_q & ocie_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctc_q  <= 1'b0;
      ocie_q <= 1'b0;
      ocf_q  <= 1'b0;
      ocr_q  <= '0;
    end else begin
      if (wr_tccr)  ctc_q  <= wdata[3];
      if (wr_timsk) ocie_q <= wdata[1];
      if (wr_ocr)   ocr_q  <= wdata;
      ocf_q <= (ocf_q & ~(wr_tifr & wdata[1])) | ocf_set;
    end
  end
`else
  assign ctc_mode  = 1'b0;
  assign ctc_clear = 1'b0;
  assign cmp_irq   = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    if (sel_tccr) rd_data[2:0] = cs_q;
    if (sel_tcnt) rd_data      = tcnt_q;
    if (sel_timsk) rd_data[0]  = toie_q;
    if (sel_tifr) rd_data[0]   = tov_q;
`ifdef TIMER_COMPARE_EN
    if (sel_tccr) rd_data[3]   = ctc_q;
    if (sel_ocr) rd_data       = ocr_q;
    if (sel_timsk) rd_data[1]  = ocie_q;
    if (sel_tifr) rd_data[1]   = ocf_q;
`else
    if (wr_ocr) rd_data = '0;
`endif
  end

  assign bus_data = rd_en ? rd_data : {DATA_WIDTH{1'bz}};
  assign irq      = (tov_q & toie_q) | cmp_irq;

endmodule
